// File: rtl/neo_pvc_pkg.sv
// neo_pvc_pkg: port numbers, bank register type, clear-sequencer states and status-word layout
// shared by the NEO-PVC banked protection unit.
package neo_pvc_pkg;

    localparam logic [3:0] PORT_STATUS    = 4'd7;
    localparam logic [3:0] PORT_BANK_BASE = 4'd8;

`ifdef PVC_COLOUR_EN
    localparam logic [3:0] PORT_COL_UNPACK = 4'd0;
    localparam logic [3:0] PORT_COL_GB     = 4'd1;
    localparam logic [3:0] PORT_COL_SR     = 4'd2;
    localparam logic [3:0] PORT_COL_PACK_L = 4'd4;
    localparam logic [3:0] PORT_COL_PACK_H = 4'd5;
    localparam logic [3:0] PORT_COL_PACKED = 4'd6;
`endif

    typedef logic [23:0] bank_t;

    typedef enum logic {CLEAR, READY} clr_state_t;

    typedef struct packed {
        logic       busy;
        logic [4:0] rsvd;
        logic [1:0] banks_log2;
        logic [7:0] zero;
    } status_t;

    function automatic logic [1:0] banks_log2(input int unsigned n);
        return (n >= 4) ? 2'd2 : (n >= 2) ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/neo_pvc_ram.sv
// neo_pvc_ram: protection RAM as two byte-wide arrays with registered read, plus the clear
// sequencer that fills every word with its own low address byte after reset.
module neo_pvc_ram
    import neo_pvc_pkg::*;
#(
    parameter int unsigned RAM_AW = 12
) (
    input  logic              CLK_48M,
    input  logic              nRESET,
    input  logic [RAM_AW-1:0] addr,
    input  logic [15:0]       din,
    input  logic              we_u,
    input  logic              we_l,
    output logic              RAM_BUSY,
    output logic [15:0]       q
);

    localparam int unsigned DEPTH = 2 ** RAM_AW;

    clr_state_t        state_q, state_d;
    logic [RAM_AW-1:0] clr_addr_q, clr_addr_d;
    logic [7:0]        mem_u [DEPTH];
    logic [7:0]        mem_l [DEPTH];
    logic [7:0]        q_u_q, q_l_q;
    logic [RAM_AW-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              wr_u, wr_l;

    always_ff @(posedge CLK_48M) begin
        if (!nRESET) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // While clearing, the sequencer owns the write port and CPU writes are dropped.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wr_addr    = addr;
        wr_data    = din;
        wr_u       = we_u;
        wr_l       = we_l;
        unique case (state_q)
            CLEAR: begin
                wr_addr    = clr_addr_q;
                wr_data    = {2{8'(clr_addr_q)}};
                wr_u       = 1'b1;
                wr_l       = 1'b1;
                clr_addr_d = clr_addr_q + RAM_AW'(1);
                if (&clr_addr_q) begin
                    state_d = READY;
                end
            end
            READY: ;
        endcase
    end

    always_ff @(posedge CLK_48M) begin
        if (wr_u) begin
            mem_u[wr_addr] <= wr_data[15:8];
        end
        if (wr_l) begin
            mem_l[wr_addr] <= wr_data[7:0];
        end
        q_u_q <= mem_u[addr];
        q_l_q <= mem_l[addr];
    end

    assign RAM_BUSY = (state_q == CLEAR);
    assign q        = RAM_BUSY ? 16'h0000 : {q_u_q, q_l_q};

endmodule

// File: rtl/neo_pvc_banked.sv
// neo_pvc_banked: banked P2 address generator with protection RAM and status port for the 68K cart
// bus. Colour pack/unpack ports are built only when PVC_COLOUR_EN is defined.
module neo_pvc_banked
    import neo_pvc_pkg::*;
#(
    parameter int unsigned NUM_BANKS = 1,
    parameter int unsigned RAM_AW    = 12,
    parameter int unsigned BANK_W    = 24
) (
    input  logic              CLK_48M,
    input  logic              nRESET,
    input  logic              ENABLE,
    input  logic [19:1]       M68K_ADDR,
    input  logic [15:0]       M68K_DIN,
    output logic [15:0]       M68K_DOUT,
    output logic              M68K_OEL,
    output logic              M68K_OEU,
    input  logic [15:0]       PROM_DATA,
    input  logic              nPORTOEL,
    input  logic              nPORTOEU,
    input  logic              nPORTWEL,
    input  logic              nPORTWEU,
    output logic [BANK_W-1:0] P2_ADDR,
    output logic              RAM_BUSY
);

    localparam int unsigned SEL_W = 32'(banks_log2(NUM_BANKS));

    logic        ram_acc, port_acc, bank_hit;
    logic [3:0]  port_no;
    logic [1:0]  bank_idx, sel;
    logic        we_u_d, we_l_d, wr_u, wr_l;
    bank_t       bank_q [4];
    bank_t       bank_sum;
    logic [19:0] slice_off;
    logic        port_hit;
    logic [15:0] port_rd, ram_q;
    status_t     status;

    assign ram_acc  = &M68K_ADDR[19:RAM_AW+1];
    assign port_acc = &M68K_ADDR[19:5];
    assign port_no  = M68K_ADDR[4:1];
    assign bank_idx = port_no[2:1];
    assign bank_hit = port_acc && (port_no >= PORT_BANK_BASE) && (32'(bank_idx) < NUM_BANKS);

    // A write is the first cycle a strobe is seen low.
    always_ff @(posedge CLK_48M) begin
        if (!nRESET) begin
            we_u_d <= 1'b1;
            we_l_d <= 1'b1;
        end else begin
            we_u_d <= nPORTWEU;
            we_l_d <= nPORTWEL;
        end
    end

    assign wr_u = ENABLE && !nPORTWEU && we_u_d;
    assign wr_l = ENABLE && !nPORTWEL && we_l_d;

    always_ff @(posedge CLK_48M) begin
        if (!nRESET) begin
            for (int i = 0; i < 4; i++) begin
                bank_q[i] <= '0;
            end
        end else if (bank_hit) begin
            if (!port_no[0]) begin
                if (wr_u) bank_q[bank_idx][7:0] <= {M68K_DIN[15:9], 1'b0};
            end else begin
                if (wr_u) bank_q[bank_idx][23:16] <= {1'b0, M68K_DIN[14:8]};
                if (wr_l) bank_q[bank_idx][15:8]  <= M68K_DIN[7:0];
            end
        end
    end

    // Top SEL_W address bits pick the bank; the rest is the byte offset inside that slice.
    assign sel       = M68K_ADDR[19:18] >> (2 - SEL_W);
    assign slice_off = {M68K_ADDR, 1'b0} & (20'hF_FFFF >> SEL_W);
    assign bank_sum  = bank_q[sel] + 24'(slice_off);
    assign P2_ADDR   = ENABLE ? BANK_W'(bank_sum) : '0;

    always_comb begin
        status            = '0;
        status.busy       = RAM_BUSY;
        status.banks_log2 = banks_log2(NUM_BANKS);
    end

`ifdef PVC_COLOUR_EN
    logic [4:0]  ur_q, ug_q, ub_q;
    logic        us_q;
    logic [15:0] pcol_q;

    always_ff @(posedge CLK_48M) begin
        if (port_acc && port_no == PORT_COL_UNPACK) begin
            if (wr_u) begin
                ub_q[0] <= M68K_DIN[12];
                ug_q[0] <= M68K_DIN[13];
                ur_q    <= {M68K_DIN[11:8], M68K_DIN[14]};
                us_q    <= M68K_DIN[15];
            end
            if (wr_l) begin
                ub_q[4:1] <= M68K_DIN[3:0];
                ug_q[4:1] <= M68K_DIN[7:4];
            end
        end
        if (port_acc && port_no == PORT_COL_PACK_L) begin
            if (wr_u) {pcol_q[13], pcol_q[7:4]} <= {M68K_DIN[8], M68K_DIN[12:9]};
            if (wr_l) {pcol_q[12], pcol_q[3:0]} <= {M68K_DIN[0], M68K_DIN[4:1]};
        end
        if (port_acc && port_no == PORT_COL_PACK_H) begin
            if (wr_u) pcol_q[15] <= M68K_DIN[8];
            if (wr_l) {pcol_q[14], pcol_q[11:8]} <= {M68K_DIN[0], M68K_DIN[4:1]};
        end
    end
`endif

    always_comb begin
        port_hit = 1'b0;
        port_rd  = '0;
        if (port_acc) begin
            if (port_no == PORT_STATUS) begin
                port_hit = 1'b1;
                port_rd  = status;
            end else if (bank_hit) begin
                port_hit = 1'b1;
                port_rd  = port_no[0] ? bank_q[bank_idx][23:8] : {bank_q[bank_idx][7:0], 8'hA0};
            end
`ifdef PVC_COLOUR_EN
            else if (port_no == PORT_COL_GB) begin
                port_hit = 1'b1;
                port_rd  = {3'b0, ug_q, 3'b0, ub_q};
            end else if (port_no == PORT_COL_SR) begin
                port_hit = 1'b1;
                port_rd  = {7'b0, us_q, 3'b0, ur_q};
            end else if (port_no == PORT_COL_PACKED) begin
                port_hit = 1'b1;
                port_rd  = pcol_q;
            end
`endif
        end
    end

    // Writes into the port window never reach the RAM, decoded or not.
    neo_pvc_ram #(
        .RAM_AW (RAM_AW)
    ) u_ram (
        .CLK_48M  (CLK_48M),
        .nRESET   (nRESET),
        .addr     (M68K_ADDR[RAM_AW:1]),
        .din      (M68K_DIN),
        .we_u     (wr_u && ram_acc && !port_acc),
        .we_l     (wr_l && ram_acc && !port_acc),
        .RAM_BUSY (RAM_BUSY),
        .q        (ram_q)
    );

    always_comb begin
        M68K_DOUT = PROM_DATA;
        if (ENABLE) begin
            if (port_hit) begin
                M68K_DOUT = port_rd;
            end else if (ram_acc) begin
                M68K_DOUT = ram_q;
            end
        end
    end

    assign M68K_OEL = nRESET && ENABLE && !nPORTOEL;
    assign M68K_OEU = nRESET && ENABLE && !nPORTOEU;

endmodule

// File: tb/tb_neo_pvc_banked.sv
// tb_neo_pvc_banked: directed bench; instance a is NUM_BANKS=1/RAM_AW=12, instance b is
// NUM_BANKS=2/RAM_AW=6, both on one shared bus. Define PVC_COLOUR_EN to cover colour ports.
`timescale 1ns/1ps
module tb_neo_pvc_banked;

    logic        clk = 1'b0;
    logic        nreset, enable;
    logic [19:1] addr;
    logic [15:0] din, prom;
    logic        noel, noeu, nwel, nweu;
    logic [15:0] dout_a, dout_b;
    logic        oel_a, oeu_a, oel_b, oeu_b;
    logic [23:0] p2_a, p2_b;
    logic        busy_a, busy_b;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          t0, guard, cnt_b;
    logic [15:0] ra, rb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    neo_pvc_banked #(.NUM_BANKS(1), .RAM_AW(12), .BANK_W(24)) dut_a (
        .CLK_48M(clk), .nRESET(nreset), .ENABLE(enable), .M68K_ADDR(addr), .M68K_DIN(din),
        .M68K_DOUT(dout_a), .M68K_OEL(oel_a), .M68K_OEU(oeu_a), .PROM_DATA(prom),
        .nPORTOEL(noel), .nPORTOEU(noeu), .nPORTWEL(nwel), .nPORTWEU(nweu),
        .P2_ADDR(p2_a), .RAM_BUSY(busy_a)
    );

    neo_pvc_banked #(.NUM_BANKS(2), .RAM_AW(6), .BANK_W(24)) dut_b (
        .CLK_48M(clk), .nRESET(nreset), .ENABLE(enable), .M68K_ADDR(addr), .M68K_DIN(din),
        .M68K_DOUT(dout_b), .M68K_OEL(oel_b), .M68K_OEU(oeu_b), .PROM_DATA(prom),
        .nPORTOEL(noel), .nPORTOEU(noeu), .nPORTWEL(nwel), .nPORTWEU(nweu),
        .P2_ADDR(p2_b), .RAM_BUSY(busy_b)
    );

    function automatic logic [19:1] port_addr(input int p);
        return 19'h7FFF0 | 19'(p);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [19:1] a, input logic [15:0] d, input logic u, input logic l);
        @(negedge clk);
        addr = a; din = d; nweu = ~u; nwel = ~l;
        @(negedge clk);
        nweu = 1'b1; nwel = 1'b1;
    endtask

    task automatic rd(input logic [19:1] a, output logic [15:0] da, output logic [15:0] db);
        @(negedge clk);
        addr = a; noel = 1'b0; noeu = 1'b0;
        @(negedge clk);
        da = dout_a; db = dout_b;
        noel = 1'b1; noeu = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        guard = 0;
        cnt_b = -1;
        while (busy_a === 1'b1 && guard < 6000) begin
            @(posedge clk); #1;
            guard++;
            if (busy_b !== 1'b1 && cnt_b < 0) cnt_b = cyc - t0;
        end
        check(tag, cyc - t0, 4096);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        nreset = 1'b0; enable = 1'b1; addr = '0; din = '0; prom = 16'hC0DE;
        noel = 1'b0; noeu = 1'b0; nwel = 1'b1; nweu = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy_a", busy_a, 1);
        check("rst_busy_b", busy_b, 1);
        check("rst_oel_a", oel_a, 0);
        check("rst_oeu_b", oeu_b, 0);
        check("rst_p2_a", p2_a, 24'h0);
        noel = 1'b1; noeu = 1'b1;
        nreset = 1'b1; t0 = cyc;
        wait_ready("clr_len_a");
        check("clr_len_b", cnt_b, 64);

        rd(19'h7F012, ra, rb);
        check("fill_a_012", ra, 16'h1212);
        check("prom_b_7f012", rb, 16'hC0DE);
        rd(19'h7FFD2, ra, rb);
        check("fill_a_fd2", ra, 16'hD2D2);
        check("fill_b_12", rb, 16'h1212);
        rd(port_addr(7), ra, rb);
        check("status_a", ra, 16'h0000);
        check("status_b", rb, 16'h0100);

        wr(port_addr(8), 16'h1300, 1, 0);
        wr(port_addr(9), 16'h8345, 1, 1);
        rd(port_addr(9), ra, rb);
        check("p9_a", ra, 16'h0345);
        check("p9_b", rb, 16'h0345);
        rd(port_addr(8), ra, rb);
        check("p8_a", ra, 16'h12A0);
        @(negedge clk); addr = 19'h00010; #1;
        check("p2_a_off10", p2_a, 24'h034532);
        check("p2_b_off10", p2_b, 24'h034532);

        wr(port_addr(9), 16'h1000, 1, 1);
        wr(port_addr(8), 16'h0000, 1, 0);
        wr(port_addr(11), 16'h2000, 1, 1);
        wr(port_addr(10), 16'h0000, 1, 0);
        @(negedge clk); addr = 19'h00100; #1;
        check("p2_a_s0", p2_a, 24'h100200);
        check("p2_b_s0", p2_b, 24'h100200);
        @(negedge clk); addr = 19'h40100; #1;
        check("p2_a_hi", p2_a, 24'h180200);
        check("p2_b_s1", p2_b, 24'h200200);
        rd(port_addr(11), ra, rb);
        check("p11_a_undec", ra, 16'hFBFB);
        check("p11_b", rb, 16'h2000);
        rd(port_addr(10), ra, rb);
        check("p10_b", rb, 16'h00A0);
        rd(port_addr(13), ra, rb);
        check("p13_b_undec", rb, 16'h3D3D);

        wr(19'h7F020, 16'hBEEF, 1, 1);
        rd(19'h7F020, ra, rb);
        check("ram_wr_a", ra, 16'hBEEF);
        check("ram_prom_b", rb, 16'hC0DE);
        wr(19'h7F020, 16'h1234, 0, 1);
        rd(19'h7F020, ra, rb);
        check("ram_wr_lo_a", ra, 16'hBE34);
        wr(19'h7FFC5, 16'hA55A, 1, 1);
        rd(19'h7FFC5, ra, rb);
        check("ram_wr_a2", ra, 16'hA55A);
        check("ram_wr_b", rb, 16'hA55A);

`ifdef PVC_COLOUR_EN
        wr(port_addr(0), 16'h8F3C, 1, 1);
        rd(port_addr(1), ra, rb);
        check("col_p1_a", ra, 16'h0618);
        check("col_p1_b", rb, 16'h0618);
        rd(port_addr(2), ra, rb);
        check("col_p2_a", ra, 16'h011E);
        wr(port_addr(4), 16'h1F1F, 1, 1);
        wr(port_addr(5), 16'h0000, 1, 1);
        rd(port_addr(6), ra, rb);
        check("col_p6_a", ra, 16'h30FF);
        check("col_p6_b", rb, 16'h30FF);
`else
        wr(port_addr(0), 16'h8F3C, 1, 1);
        rd(port_addr(0), ra, rb);
        check("nocol_p0_a", ra, 16'hF0F0);
        rd(port_addr(1), ra, rb);
        check("nocol_p1_a", ra, 16'hF1F1);
        check("nocol_p1_b", rb, 16'h3131);
        rd(port_addr(6), ra, rb);
        check("nocol_p6_a", ra, 16'hF6F6);
`endif

        enable = 1'b0;
        wr(port_addr(8), 16'hFE00, 1, 0);
        wr(19'h7F020, 16'h5555, 1, 1);
        @(negedge clk); addr = port_addr(8); noel = 1'b0; #1;
        check("dis_oel_a", oel_a, 0);
        check("dis_p2_a", p2_a, 24'h0);
        check("dis_dout_a", dout_a, 16'hC0DE);
        @(negedge clk); noel = 1'b1;
        enable = 1'b1;
        rd(port_addr(8), ra, rb);
        check("dis_bank_a", ra, 16'h00A0);
        check("dis_bank_b", rb, 16'h00A0);
        rd(19'h7F020, ra, rb);
        check("dis_ram_a", ra, 16'hBE34);
        @(negedge clk); addr = port_addr(8); noel = 1'b0; #1;
        check("en_oel_a", oel_a, 1);
        @(negedge clk); noel = 1'b1;

        nreset = 1'b0;
        @(negedge clk); @(negedge clk);
        nreset = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk); nreset = 1'b0;
        @(negedge clk); @(negedge clk);
        check("midclr_busy_a", busy_a, 1);
        nreset = 1'b1; t0 = cyc;
        repeat (50) @(posedge clk);
        wr(19'h7F012, 16'hBEEF, 1, 1);
        rd(19'h7F012, ra, rb);
        check("busy_ram_rd_a", ra, 16'h0000);
        rd(port_addr(7), ra, rb);
        check("busy_status_a", ra, 16'h8000);
        rd(port_addr(9), ra, rb);
        check("rst_bank_a", ra, 16'h0000);
        check("rst_bank_b", rb, 16'h0000);
        wait_ready("reclr_len_a");
        rd(19'h7F012, ra, rb);
        check("post_clr_a", ra, 16'h1212);
        rd(19'h7F020, ra, rb);
        check("post_clr_a2", ra, 16'h2020);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
